bitwise_sweep_checker: RTL and testbench

//  Self-checking response side for N-bit bitwise gate arrays (OR2/AND2/XOR2 slices).

---
 rtl/bitwise_sweep_pkg.sv | 21 ++
 rtl/bitwise_sweep_pipe.sv | 39 +++
 rtl/bitwise_sweep_checker.sv | 146 ++++++++++++++
 tb/tb_bitwise_sweep_checker.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/bitwise_sweep_pkg.sv
// bitwise_sweep_pkg: shared types, the reference gate function and MISR feedback taps
// for the bitwise sweep checker.
package bitwise_sweep_pkg;

    typedef enum logic [1:0] {OP_OR, OP_AND, OP_XOR, OP_NOR} op_e;

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, PASS, FAIL} state_e;

    // Galois feedback taps of a primitive polynomial for each width 1..12
    localparam logic [11:0] MISR_TAPS [1:12] = '{
        12'h001, 12'h003, 12'h003, 12'h003, 12'h005, 12'h003,
        12'h003, 12'h01D, 12'h011, 12'h009, 12'h005, 12'h053
    };

    function automatic logic [11:0] bitwise_eval(input op_e op, input logic [11:0] a, input logic [11:0] b);
        return op == OP_OR  ? (a | b) :
               op == OP_AND ? (a & b) :
               op == OP_XOR ? (a ^ b) : ~(a | b);
    endfunction

endpackage

// File: rtl/bitwise_sweep_pipe.sv
// bitwise_sweep_pipe: LAT-deep delay line aligning expected result, operands and a valid
// bit with the DUT response; LAT=0 is a pure wire.
module bitwise_sweep_pipe
    import bitwise_sweep_pkg::*;
#(
    parameter int LAT = 1,
    parameter int D   = 1
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         v_i,
    input  logic [D-1:0] d_i,
    output logic         v_o,
    output logic [D-1:0] d_o
);

    generate
        if (LAT == 0) begin : g_wire
            assign v_o = v_i;
            assign d_o = d_i;
        end else begin : g_reg
            logic [LAT-1:0]        v_q;
            logic [LAT-1:0][D-1:0] d_q;
            always_ff @(posedge clk) begin
                if (clr) begin
                    v_q <= '0;
                end else begin
                    v_q[0] <= v_i;
                    for (int i = 1; i < LAT; i++) v_q[i] <= v_q[i-1];
                end
                d_q[0] <= d_i;
                for (int i = 1; i < LAT; i++) d_q[i] <= d_q[i-1];
            end
            assign v_o = v_q[LAT-1];
            assign d_o = d_q[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/bitwise_sweep_checker.sv
// bitwise_sweep_checker: exhaustive A/B operand sweep with latency-aligned compare of z_in.
// Define MISR_SIGNATURE_EN to add a W-bit MISR signature over every compared z_in.
module bitwise_sweep_checker
    import bitwise_sweep_pkg::*;
#(
    parameter int W            = 8,
    parameter int LAT          = 1,
    parameter int STOP_ON_FAIL = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    output logic [W-1:0]     a_out,
    output logic [W-1:0]     b_out,
    input  logic [W-1:0]     z_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [W-1:0]     fail_a,
    output logic [W-1:0]     fail_b,
`ifdef MISR_SIGNATURE_EN
    output logic [W-1:0]     signature,
`endif
    output logic [W-1:0]     fail_z
);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d;
    logic [W-1:0]     fa_q, fa_d, fb_q, fb_d, fz_q, fz_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [2:0]       dcnt_q, dcnt_d;
    logic             busy_q, done_q, pass_q;
    logic             run, drain, act, last, start_ok, mism, fin;
    logic             v_o;
    logic [W-1:0]     exp_i, exp_p, a_p, b_p;

    assign run      = state_q == RUN;
    assign drain    = state_q == DRAIN;
    assign act      = run || drain;
    assign last     = &a_q && &b_q;
    assign start_ok = start && !act;
    assign exp_i    = W'(bitwise_eval(op_q, 12'(a_q), 12'(b_q)));

    bitwise_sweep_pipe #(.LAT(LAT), .D(3*W)) u_pipe (
        .clk (clk),
        .clr (reset || !act),
        .v_i (run),
        .d_i ({exp_i, a_q, b_q}),
        .v_o (v_o),
        .d_o ({exp_p, a_p, b_p})
    );

    // 4-state inequality so X/Z on the DUT result is never silently accepted
    assign mism = act && v_o && (z_in !== exp_p);
    assign fin  = (run && last && LAT == 0) || (drain && int'(dcnt_q) == LAT - 1);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        fa_d    = fa_q;
        fb_d    = fb_q;
        fz_d    = fz_q;
        err_d   = (mism && !(&err_q)) ? err_q + 1'b1 : err_q;
        dcnt_d  = drain ? dcnt_q + 3'd1 : 3'd0;
        if (start_ok) begin
            state_d = RUN;
            op_d    = op_e'(op);
            a_d     = '0;
            b_d     = '0;
            fa_d    = '0;
            fb_d    = '0;
            fz_d    = '0;
            err_d   = '0;
        end else if (act) begin
            if (mism && err_q == '0) begin
                fa_d = a_p;
                fb_d = b_p;
                fz_d = z_in;
            end
            if (mism && STOP_ON_FAIL != 0) state_d = FAIL;
            else if (fin)                  state_d = (err_q != '0 || mism) ? FAIL : PASS;
            else if (run && last)          state_d = DRAIN;
            if (run && !last) begin
                b_d = b_q + 1'b1;
                a_d = &b_q ? a_q + 1'b1 : a_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_OR;
            a_q     <= '0;
            b_q     <= '0;
            fa_q    <= '0;
            fb_q    <= '0;
            fz_q    <= '0;
            err_q   <= '0;
            dcnt_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            fa_q    <= fa_d;
            fb_q    <= fb_d;
            fz_q    <= fz_d;
            err_q   <= err_d;
            dcnt_q  <= dcnt_d;
            busy_q  <= state_d == RUN || state_d == DRAIN;
            done_q  <= act && (state_d == PASS || state_d == FAIL);
            pass_q  <= state_d == PASS;
        end
    end

`ifdef MISR_SIGNATURE_EN
    localparam logic [W-1:0] POLY = W'(MISR_TAPS[W]);
    logic [W-1:0] sig_q;
    always_ff @(posedge clk) begin
        if (reset || start_ok) sig_q <= '0;
        else if (act && v_o)   sig_q <= (sig_q << 1) ^ (sig_q[W-1] ? POLY : '0) ^ z_in;
    end
    assign signature = sig_q;
`endif

    assign a_out     = a_q;
    assign b_out     = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_a    = fa_q;
    assign fail_b    = fb_q;
    assign fail_z    = fz_q;

endmodule

// File: tb/tb_bitwise_sweep_checker.sv
// tb_bitwise_sweep_checker: five W=4 checker instances (varied LAT/STOP_ON_FAIL) each beside
// a behavioural gate-array DUT with optional stuck-bit and X faults.
module tb_bitwise_sweep_checker;

    localparam int LATS  [5] = '{1, 1, 3, 2, 0};
    localparam int SOFS  [5] = '{1, 0, 1, 1, 1};
    localparam int DLATS [5] = '{1, 1, 3, 3, 0};
    localparam int OPM   [5] = '{0, 0, 2, 2, 1};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [1:0] op_r = 2'd0;
    logic [4:0] start_v = '0, flt_v = '0, xi_v = '0;
    logic [4:0] busy_v, done_v, pass_v;
    logic [4:0][3:0] a_v, b_v, z_v, fa_v, fb_v, fz_v;
    logic [4:0][15:0] ec_v;
`ifdef MISR_SIGNATURE_EN
    logic [4:0][3:0] sig_v;
`endif
    int n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    function automatic logic [3:0] fm(input int o, input logic [3:0] a, input logic [3:0] b);
        return o == 0 ? (a | b) : o == 1 ? (a & b) : o == 2 ? (a ^ b) : ~(a | b);
    endfunction

    for (genvar i = 0; i < 5; i++) begin : g
        logic [3:0] f, zc;
        logic [3:0] d [3];
        assign f  = fm(OPM[i], a_v[i], b_v[i]);
        assign zc = flt_v[i] ? (f & 4'b1011) : (xi_v[i] && a_v[i] == 4'd3 && b_v[i] == 4'd5) ? 4'bx : f;
        always @(posedge clk) begin
            d[0] <= zc;
            d[1] <= d[0];
            d[2] <= d[1];
        end
        if (DLATS[i] == 0) begin : g0
            assign z_v[i] = zc;
        end else begin : g1
            assign z_v[i] = d[DLATS[i]-1];
        end
        bitwise_sweep_checker #(.W(4), .LAT(LATS[i]), .STOP_ON_FAIL(SOFS[i]), .CNT_W(16)) u (
            .clk       (clk),
            .reset     (reset),
            .start     (start_v[i]),
            .op        (op_r),
            .a_out     (a_v[i]),
            .b_out     (b_v[i]),
            .z_in      (z_v[i]),
            .busy      (busy_v[i]),
            .done      (done_v[i]),
            .pass      (pass_v[i]),
            .err_count (ec_v[i]),
            .fail_a    (fa_v[i]),
            .fail_b    (fb_v[i]),
`ifdef MISR_SIGNATURE_EN
            .signature (sig_v[i]),
`endif
            .fail_z    (fz_v[i])
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Pulse start, then count busy cycles at negedges; returns at the first idle negedge
    task automatic sweep(input int k, input int extra_at, output int cyc);
        @(negedge clk);
        start_v[k] = 1'b1;
        @(negedge clk);
        start_v[k] = 1'b0;
        cyc = 0;
        while (busy_v[k] && cyc < 5000) begin
            cyc++;
            start_v[k] = (cyc == extra_at);
            @(negedge clk);
        end
        start_v[k] = 1'b0;
    endtask

    typedef struct {
        int         k;
        logic [1:0] op;
        logic       flt;
        logic       xi;
        logic       ps;
        int         err;
        logic [3:0] fa;
        logic [3:0] fb;
        logic [3:0] fz;
        logic       chz;
        int         cyc;
    } vec_t;

    initial begin
        vec_t tv [7];
        int cyc, k, w;
        tv = '{
            '{0, 2'd0, 1'b0, 1'b0, 1'b1,   0, 4'd0, 4'd0, 4'd0, 1'b1, 257},
            '{0, 2'd0, 1'b1, 1'b0, 1'b0,   1, 4'd0, 4'd4, 4'd0, 1'b1,   6},
            '{1, 2'd0, 1'b1, 1'b0, 1'b0, 192, 4'd0, 4'd4, 4'd0, 1'b1, 257},
            '{2, 2'd2, 1'b0, 1'b0, 1'b1,   0, 4'd0, 4'd0, 4'd0, 1'b1, 259},
            '{3, 2'd2, 1'b0, 1'b0, 1'b0,   1, 4'd0, 4'd1, 4'd0, 1'b1,   4},
            '{4, 2'd1, 1'b0, 1'b0, 1'b1,   0, 4'd0, 4'd0, 4'd0, 1'b1, 256},
            '{0, 2'd0, 1'b0, 1'b1, 1'b0,   1, 4'd3, 4'd5, 4'd0, 1'b0,  55}
        };
        do_reset();
        chk("rst_busy", {27'd0, busy_v}, 32'd0);
        chk("rst_done", {27'd0, done_v}, 32'd0);
        chk("rst_pass", {27'd0, pass_v}, 32'd0);
        chk("rst_ab", {a_v, b_v}, 32'd0);
        chk("rst_err", ec_v[0], 32'd0);

        for (int r = 0; r < 7; r++) begin
            k = tv[r].k;
            do_reset();
            flt_v[k] = tv[r].flt;
            xi_v[k]  = tv[r].xi;
            op_r     = tv[r].op;
            sweep(k, 0, cyc);
            chk($sformatf("r%0d_cycles", r), cyc, tv[r].cyc);
            chk($sformatf("r%0d_done", r), done_v[k], 1'b1);
            chk($sformatf("r%0d_pass", r), pass_v[k], tv[r].ps);
            chk($sformatf("r%0d_err", r), ec_v[k], tv[r].err);
            chk($sformatf("r%0d_fail_a", r), fa_v[k], tv[r].fa);
            chk($sformatf("r%0d_fail_b", r), fb_v[k], tv[r].fb);
            if (tv[r].chz) chk($sformatf("r%0d_fail_z", r), fz_v[k], tv[r].fz);
            else           chk($sformatf("r%0d_fail_z_bad", r), fz_v[k] !== 4'd7, 1'b1);
            @(negedge clk);
            chk($sformatf("r%0d_done_drop", r), done_v[k], 1'b0);
            xi_v[k] = 1'b0;
        end

        // restart straight out of FAIL: start must clear the previous results
        do_reset();
        op_r = 2'd0;
        flt_v[0] = 1'b1;
        sweep(0, 0, cyc);
        chk("fail_before_restart", pass_v[0], 1'b0);
        flt_v[0] = 1'b0;
        sweep(0, 0, cyc);
        chk("restart_cycles", cyc, 257);
        chk("restart_pass", pass_v[0], 1'b1);
        chk("restart_err", ec_v[0], 0);
        chk("restart_fail_b", fb_v[0], 0);

        // reset mid-sweep at vector 100
        sweep(0, 0, cyc);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        w = 0;
        while (!(a_v[0] == 4'd6 && b_v[0] == 4'd4) && w < 1000) begin
            @(negedge clk);
            w++;
        end
        chk("reach_v100", w < 1000, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", busy_v[0], 1'b0);
        chk("midrst_done", done_v[0], 1'b0);
        chk("midrst_pass", pass_v[0], 1'b0);
        chk("midrst_ab", {a_v[0], b_v[0]}, 0);
        @(negedge clk);
        chk("midrst_no_done", done_v[0], 1'b0);
        chk("midrst_idle", busy_v[0], 1'b0);

        // clean sweep after reset, with an extra start while busy that must be ignored
        sweep(0, 10, cyc);
        chk("busy_start_cycles", cyc, 257);
        chk("busy_start_pass", pass_v[0], 1'b1);
        chk("final_hold_ab", {a_v[0], b_v[0]}, 8'hFF);
`ifdef MISR_SIGNATURE_EN
        begin
            logic [3:0] gs;
            gs = 4'd0;
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    gs = {gs[2:0], 1'b0} ^ (gs[3] ? 4'h3 : 4'h0) ^ (4'(a) | 4'(b));
            chk("signature", sig_v[0], gs);
        end
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
